// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and small op-decode helpers.
package mult_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE
    } md_state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mult_div_iter.sv
// Iterative signed/unsigned WIDTH x WIDTH multiply and WIDTH / WIDTH divide,
// one bit per cycle, with start/busy/done handshake and HI/LO result registers.
module mult_div_iter
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t        r_state;
    md_state_t        w_next_state;

    logic [1:0]       r_op;
    logic [2*WIDTH:0] r_work;      // mult: {carry, product}; div: {remainder, quotient}
    logic [WIDTH-1:0] r_divisor;   // multiplicand or divisor magnitude
    logic [CW-1:0]    r_count;
    logic             r_neg_q;     // negate product (mult) or quotient (div)
    logic             r_neg_r;     // negate remainder
    logic             r_dz_pending;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;

    logic             w_is_div;
    logic             w_is_signed;
    logic             w_a_sign;
    logic             w_b_sign;
    logic [WIDTH-1:0] w_a_neg;
    logic [WIDTH-1:0] w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;

    logic [WIDTH:0]   w_mul_sum;
    logic [2*WIDTH:0] w_mul_next;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;
    logic [2*WIDTH:0] w_div_next;

    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;

    assign w_is_div    = op_is_div(r_op);
    assign w_is_signed = op_is_signed(r_op);

    // In LOAD, r_work[WIDTH-1:0] and r_divisor still hold the raw operands.
    assign w_a_sign = w_is_signed & r_work[WIDTH-1];
    assign w_b_sign = w_is_signed & r_divisor[WIDTH-1];
    assign w_a_neg  = -r_work[WIDTH-1:0];
    assign w_b_neg  = -r_divisor;
    assign w_a_mag  = w_a_sign ? w_a_neg : r_work[WIDTH-1:0];
    assign w_b_mag  = w_b_sign ? w_b_neg : r_divisor;
    assign w_b_zero = (r_divisor == '0);

    // Shift-add step: add multiplicand into the upper half, then shift right.
    assign w_mul_sum  = {1'b0, r_work[2*WIDTH-1:WIDTH]} + {1'b0, r_divisor};
    assign w_mul_next = r_work[0] ? {1'b0, w_mul_sum, r_work[WIDTH-1:1]}
                                  : {1'b0, r_work[2*WIDTH:1]};

    // Restoring step: shift in next dividend bit, subtract when it fits.
    assign w_div_shift = {r_work[2*WIDTH-1:WIDTH], r_work[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_divisor};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_divisor});
    assign w_div_next  = w_div_ge ? {w_div_diff,  r_work[WIDTH-2:0], 1'b1}
                                  : {w_div_shift, r_work[WIDTH-2:0], 1'b0};

    assign w_prod_neg = -r_work[2*WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];
    assign w_quo_fix  = r_neg_q ? -r_work[WIDTH-1:0]       : r_work[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so every register
            // samples pre-edge values and process ordering cannot matter.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives the signal and no
        // latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            IDLE: if (start) w_next_state = LOAD;
            LOAD: w_next_state = (w_is_div && w_b_zero) ? DONE : CALC;
            CALC: if (r_count == CW'(WIDTH - 1)) w_next_state = FIX;
            FIX:  w_next_state = DONE;
            DONE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op         <= OP_MULT;
            r_work       <= '0;
            r_divisor    <= '0;
            r_count      <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_dz_pending <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_div_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_busy <= start;
                    if (start) begin
                        r_op       <= op;
                        r_work     <= {{(WIDTH + 1){1'b0}}, a};
                        r_divisor  <= b;
                        r_div_zero <= 1'b0;
                    end
                end
                LOAD: begin
                    r_work       <= {{(WIDTH + 1){1'b0}}, w_a_mag};
                    r_divisor    <= w_b_mag;
                    r_neg_q      <= w_a_sign ^ w_b_sign;
                    r_neg_r      <= w_a_sign;
                    r_dz_pending <= w_is_div & w_b_zero;
                    r_count      <= '0;
                end
                CALC: begin
                    r_work  <= w_is_div ? w_div_next : w_mul_next;
                    r_count <= r_count + CW'(1);
                end
                FIX: begin
                    if (w_is_div) begin
                        r_work <= {1'b0, w_rem_fix, w_quo_fix};
                    end else if (r_neg_q) begin
                        r_work <= {1'b0, w_prod_neg};
                    end
                end
                DONE: begin
                    r_done     <= 1'b1;
                    r_div_zero <= r_dz_pending;
                    if (!r_dz_pending) begin
                        r_hi <= r_work[2*WIDTH-1:WIDTH];
                        r_lo <= r_work[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_iter.sv
// Scoreboard bench for mult_div_iter: the driver queues hand-computed results,
// a monitor compares them whenever done pulses.
module tb_mult_div_iter;
    import mult_div_pkg::*;

    localparam int W = 32;
    localparam int LAT    = W + 3;
    localparam int LAT_DZ = 2;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = OP_MULT;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    mult_div_iter #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           at;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                e = sb.pop_front();
                check("hi",            64'(hi),       64'(e.hi));
                check("lo",            64'(lo),       64'(e.lo));
                check("div_zero",      64'(div_zero), 64'(e.dz));
                check("done_cycle",    64'(cyc),      64'(e.at));
                check("busy_at_done",  64'(busy),     64'd1);
            end
        end
    end

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        check("done_within_bound", 64'(got), 64'd1);
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                         input logic e_dz, input int lat);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e.hi  = e_hi;
        e.lo  = e_lo;
        e.dz  = e_dz;
        e.at  = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                          input logic e_dz, input int lat);
        issue(o, x, y, e_hi, e_lo, e_dz, lat);
        wait_done();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_hi",       64'(hi),       64'd0);
        check("rst_lo",       64'(lo),       64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(OP_MULT,  32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT);
        run_op(OP_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, LAT);
        run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, LAT);
        run_op(OP_DIVU,  32'h0000_3412, 32'h0000_0100, 32'h0000_0012, 32'h0000_0034, 1'b0, LAT);
        run_op(OP_DIVU,  32'd100,      32'd0,        32'h0000_0012, 32'h0000_0034, 1'b1, LAT_DZ);
        run_op(OP_MULTU, 32'd3,        32'd4,        32'h0000_0000, 32'd12,        1'b0, LAT);
        run_op(OP_DIV,   32'd5,        32'd0,        32'h0000_0000, 32'd12,        1'b1, LAT_DZ);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, LAT);
        run_op(OP_MULT,  32'h8000_0000, 32'd2,        32'hFFFF_FFFF, 32'h0000_0000, 1'b0, LAT);

        // A start while busy must be dropped: only the first result appears.
        issue(OP_MULT, 32'd5, 32'd6, 32'h0, 32'd30, 1'b0, LAT);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd9;
        b     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // Reset mid-operation aborts without ever pulsing done.
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd7;
        b     = 32'hFFFF_FFFD;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy",     64'(busy),     64'd0);
        check("abort_done",     64'(done),     64'd0);
        check("abort_hi",       64'(hi),       64'd0);
        check("abort_lo",       64'(lo),       64'd0);
        check("abort_div_zero", 64'(div_zero), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_after_abort", 64'(busy), 64'd0);

        run_op(OP_MULTU, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, LAT);

        repeat (2) @(negedge clk);
        check("pending_results", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
